// File: rtl/pj_store_buffer_pkg.sv
// Shared types and default sizes for the pj_store_buffer slice.
// Buffer entries are {addr, data} pairs held in an in-order circular buffer.
package pj_store_buffer_pkg;

    localparam int SB_WORD_SIZE = 16;
    localparam int SB_ADDR_W    = 16;
    localparam int SB_DEPTH     = 8;

    typedef struct packed {
        logic [SB_ADDR_W-1:0]    addr;
        logic [SB_WORD_SIZE-1:0] data;
    } sb_entry_s;

endpackage

// File: rtl/pj_sb_cam.sv
// Associative lookup over the store buffer: returns the youngest valid entry
// whose address matches, scanning from wr_ptr-1 back towards the oldest entry.
module pj_sb_cam
    import pj_store_buffer_pkg::*;
#(
    parameter  int DEPTH_P = SB_DEPTH,
    localparam int PTR_W   = $clog2(DEPTH_P)
) (
    input  sb_entry_s               entries [DEPTH_P],
    input  logic [DEPTH_P-1:0]      valid,
    input  logic [PTR_W-1:0]        wr_ptr,
    input  logic [SB_ADDR_W-1:0]    lookup_addr,
    output logic                    hit,
    output logic [PTR_W-1:0]        hit_idx,
    output logic [SB_WORD_SIZE-1:0] hit_data
);

    logic [PTR_W-1:0] idx;

    always_comb begin
        hit      = 1'b0;
        hit_idx  = '0;
        hit_data = '0;
        idx      = '0;
        // k = DEPTH_P wraps back onto wr_ptr itself, the oldest slot when full
        for (int k = 1; k <= DEPTH_P; k++) begin
            idx = wr_ptr - PTR_W'(k);
            if (!hit && valid[idx] && (entries[idx].addr == lookup_addr)) begin
                hit      = 1'b1;
                hit_idx  = idx;
                hit_data = entries[idx].data;
            end
        end
    end

endmodule

// File: rtl/pj_store_buffer.sv
// Store buffer between core data port and single-port SRAM: in-order FIFO,
// same-cycle load forwarding, drain on idle/hit cycles. Option: PJ_SB_COALESCE_EN.
module pj_store_buffer
    import pj_store_buffer_pkg::*;
#(
    parameter int WORD_SIZE_P = SB_WORD_SIZE,
    parameter int ADDR_W_P    = SB_ADDR_W,
    parameter int DEPTH_P     = SB_DEPTH
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   w_v_i,
    input  logic [ADDR_W_P-1:0]    w_addr_i,
    input  logic [WORD_SIZE_P-1:0] w_data_i,
    input  logic                   r_v_i,
    input  logic [ADDR_W_P-1:0]    r_addr_i,
    output logic [WORD_SIZE_P-1:0] r_data_o,
    output logic                   mem_v_o,
    output logic                   mem_w_o,
    output logic [ADDR_W_P-1:0]    mem_addr_o,
    output logic [WORD_SIZE_P-1:0] mem_data_o,
    input  logic [WORD_SIZE_P-1:0] mem_data_i,
    output logic                   full_o,
    output logic                   empty_o,
    output logic                   overflow_o
);

    localparam int PTR_W = $clog2(DEPTH_P);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH_P);

    sb_entry_s          entries [DEPTH_P];
    sb_entry_s          head;
    logic [PTR_W-1:0]   rd_ptr, wr_ptr;
    logic [CNT_W-1:0]   count;
    logic               overflow_q;
    logic [DEPTH_P-1:0] valid;

    logic                   ld_hit;
    logic [PTR_W-1:0]       ld_idx;
    logic [WORD_SIZE_P-1:0] ld_data;
    logic                   unused_ld_idx;
    logic                   drain, accept, coalesce;

    for (genvar gi = 0; gi < DEPTH_P; gi++) begin : g_valid
        logic [PTR_W-1:0] off;
        assign off       = PTR_W'(gi) - rd_ptr;
        assign valid[gi] = {1'b0, off} < count;
    end

    pj_sb_cam #(.DEPTH_P(DEPTH_P)) u_load_cam (
        .entries     (entries),
        .valid       (valid),
        .wr_ptr      (wr_ptr),
        .lookup_addr (r_addr_i),
        .hit         (ld_hit),
        .hit_idx     (ld_idx),
        .hit_data    (ld_data)
    );
    assign unused_ld_idx = ^ld_idx;

    assign empty_o    = (count == '0);
    assign full_o     = (count == DEPTH_C);
    assign overflow_o = overflow_q;
    assign head       = entries[rd_ptr];

    // The SRAM port belongs to a missing load; otherwise the head entry drains.
    assign drain      = !empty_o && (!r_v_i || ld_hit);
    assign mem_v_o    = (r_v_i && !ld_hit) || drain;
    assign mem_w_o    = drain;
    assign mem_addr_o = drain ? head.addr : r_addr_i;
    assign mem_data_o = head.data;
    assign r_data_o   = ld_hit ? ld_data : mem_data_i;

`ifdef PJ_SB_COALESCE_EN
    logic                   co_hit;
    logic [PTR_W-1:0]       co_idx;
    logic [WORD_SIZE_P-1:0] co_data;
    logic                   unused_co_data;

    pj_sb_cam #(.DEPTH_P(DEPTH_P)) u_coalesce_cam (
        .entries     (entries),
        .valid       (valid),
        .wr_ptr      (wr_ptr),
        .lookup_addr (w_addr_i),
        .hit         (co_hit),
        .hit_idx     (co_idx),
        .hit_data    (co_data)
    );
    assign unused_co_data = ^co_data;

    // Merging into the entry that is leaving this cycle would lose the store.
    assign coalesce = w_v_i && co_hit && !(drain && (co_idx == rd_ptr));
`else
    assign coalesce = 1'b0;
`endif

    // Store handshake: w_v_i is a committed store with no ready; the core must
    // watch full_o, and a store that finds no room is dropped and flagged.
    assign accept = w_v_i && !coalesce && (!full_o || drain);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (drain)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (accept) wr_ptr <= wr_ptr + PTR_W'(1);
            count <= count + CNT_W'(accept) - CNT_W'(drain);
            if (w_v_i && !coalesce && !accept) overflow_q <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (accept) begin
            entries[wr_ptr].addr <= w_addr_i;
            entries[wr_ptr].data <= w_data_i;
        end
`ifdef PJ_SB_COALESCE_EN
        if (coalesce) entries[co_idx].data <= w_data_i;
`endif
    end

endmodule

// File: tb/tb_pj_store_buffer.sv
// Bench for pj_store_buffer: directed vector table, reset-mid-drain sequence,
// and randomized traffic checked against a queue-based store-buffer model.
module tb_pj_store_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        w_v, r_v;
    logic [15:0] w_addr, w_data, r_addr;
    logic [15:0] r_data_o, mem_addr_o, mem_data_o, mem_data_i;
    logic        mem_v_o, mem_w_o, full_o, empty_o, overflow_o;

    int errors = 0;
    int checks = 0;

    logic [15:0] sram [0:255];
    logic        sram_init = 1'b0;
    logic [15:0] gold [0:255];

    typedef struct packed {
        logic [15:0] addr;
        logic [15:0] data;
    } ent_t;
    ent_t m_q[$];
    bit   m_ovf;

    typedef struct {
        logic        w_v;
        logic [15:0] w_addr, w_data;
        logic        r_v;
        logic [15:0] r_addr;
        logic        e_mem_v, e_mem_w;
        logic [15:0] e_mem_addr, e_mem_data;
        logic        chk_rd;
        logic [15:0] e_rdata;
        logic        e_full, e_empty, e_ovf;
    } vec_t;
    vec_t tbl[$];

    pj_store_buffer dut (
        .clk_i      (clk),
        .reset_i    (rst),
        .w_v_i      (w_v),
        .w_addr_i   (w_addr),
        .w_data_i   (w_data),
        .r_v_i      (r_v),
        .r_addr_i   (r_addr),
        .r_data_o   (r_data_o),
        .mem_v_o    (mem_v_o),
        .mem_w_o    (mem_w_o),
        .mem_addr_o (mem_addr_o),
        .mem_data_o (mem_data_o),
        .mem_data_i (mem_data_i),
        .full_o     (full_o),
        .empty_o    (empty_o),
        .overflow_o (overflow_o)
    );

    // clock / SRAM behaviour
    always #5 clk = ~clk;

    assign mem_data_i = sram[mem_addr_o[7:0]];

    always @(posedge clk) begin
        if (sram_init) begin
            for (int i = 0; i < 256; i++) sram[i] <= 16'h5000 + 16'(i);
        end else if (mem_v_o && mem_w_o) begin
            sram[mem_addr_o[7:0]] <= mem_data_o;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic wv, input logic [15:0] wa, input logic [15:0] wd,
                         input logic rv, input logic [15:0] ra);
        w_v = wv; w_addr = wa; w_data = wd; r_v = rv; r_addr = ra;
    endtask

    task automatic do_reset(input bit init_mem);
        drive(1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
        rst       = 1'b1;
        sram_init = init_mem;
        @(posedge clk);
        #1 sram_init = 1'b0;
        if (init_mem) for (int i = 0; i < 256; i++) gold[i] = 16'h5000 + 16'(i);
        m_q.delete();
        m_ovf = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    function automatic vec_t mk(input logic wv, input logic [15:0] wa, input logic [15:0] wd,
                                input logic rv, input logic [15:0] ra,
                                input logic mv, input logic mw, input logic [15:0] ma,
                                input logic [15:0] md, input logic cr, input logic [15:0] rd,
                                input logic fu, input logic em, input logic ov);
        vec_t v;
        v.w_v = wv; v.w_addr = wa; v.w_data = wd; v.r_v = rv; v.r_addr = ra;
        v.e_mem_v = mv; v.e_mem_w = mw; v.e_mem_addr = ma; v.e_mem_data = md;
        v.chk_rd = cr; v.e_rdata = rd; v.e_full = fu; v.e_empty = em; v.e_ovf = ov;
        return v;
    endfunction

    // One cycle of randomized traffic, checked against the FIFO model.
    task automatic model_step(input logic wv, input logic [15:0] wa, input logic [15:0] wd,
                              input logic rv, input logic [15:0] ra);
        int hit_i;
        int co_i;
        int sz;
        bit drain;
        bit coal;
        drive(wv, wa, wd, rv, ra);
        #4;
        hit_i = -1;
        for (int i = m_q.size() - 1; i >= 0; i--)
            if (hit_i < 0 && m_q[i].addr == ra) hit_i = i;
        drain = (m_q.size() != 0) && (!rv || hit_i >= 0);
        chk("rnd full", full_o, m_q.size() == 8);
        chk("rnd empty", empty_o, m_q.size() == 0);
        chk("rnd overflow", overflow_o, m_ovf);
        chk("rnd mem_v", mem_v_o, (rv && hit_i < 0) || drain);
        if (drain) begin
            chk("rnd drain mem_w", mem_w_o, 1);
            chk("rnd drain addr", mem_addr_o, m_q[0].addr);
            chk("rnd drain data", mem_data_o, m_q[0].data);
        end else if (rv) begin
            chk("rnd miss mem_w", mem_w_o, 0);
            chk("rnd miss addr", mem_addr_o, ra);
        end
        if (rv) chk("rnd r_data", r_data_o, (hit_i >= 0) ? m_q[hit_i].data : gold[ra[7:0]]);

        sz   = m_q.size();
        coal = 1'b0;
        co_i = -1;
`ifdef PJ_SB_COALESCE_EN
        for (int i = 0; i < m_q.size(); i++) if (m_q[i].addr == wa) co_i = i;
        if (wv && co_i >= 0 && !(drain && co_i == 0)) begin
            coal = 1'b1;
            m_q[co_i].data = wd;
        end
`endif
        if (drain) begin
            gold[m_q[0].addr[7:0]] = m_q[0].data;
            void'(m_q.pop_front());
        end
        if (wv && !coal) begin
            if (sz < 8 || drain) m_q.push_back('{addr: wa, data: wd});
            else m_ovf = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
        do_reset(1'b1);

        // idle after reset
        tbl.push_back(mk(0, 16'h0, 16'h0, 0, 16'h0, 0, 0, 16'h0, 16'h0, 0, 16'h0, 0, 1, 0));
        // same-cycle store is not forwarded; next cycle it is, and it drains
        tbl.push_back(mk(1, 16'h10, 16'h1234, 1, 16'h10, 1, 0, 16'h10, 16'h0, 1, 16'h5010, 0, 1, 0));
        tbl.push_back(mk(0, 16'h0, 16'h0, 1, 16'h10, 1, 1, 16'h10, 16'h1234, 1, 16'h1234, 0, 0, 0));
        // duplicate address; missing loads hold the drain off
        tbl.push_back(mk(1, 16'h20, 16'h1, 1, 16'h30, 1, 0, 16'h30, 16'h0, 1, 16'h5030, 0, 1, 0));
        tbl.push_back(mk(1, 16'h20, 16'h2, 1, 16'h30, 1, 0, 16'h30, 16'h0, 1, 16'h5030, 0, 0, 0));
        tbl.push_back(mk(0, 16'h0, 16'h0, 1, 16'h30, 1, 0, 16'h30, 16'h0, 1, 16'h5030, 0, 0, 0));
`ifdef PJ_SB_COALESCE_EN
        tbl.push_back(mk(0, 16'h0, 16'h0, 1, 16'h20, 1, 1, 16'h20, 16'h2, 1, 16'h2, 0, 0, 0));
        tbl.push_back(mk(0, 16'h0, 16'h0, 0, 16'h0, 0, 0, 16'h0, 16'h0, 0, 16'h0, 0, 1, 0));
`else
        tbl.push_back(mk(0, 16'h0, 16'h0, 1, 16'h20, 1, 1, 16'h20, 16'h1, 1, 16'h2, 0, 0, 0));
        tbl.push_back(mk(0, 16'h0, 16'h0, 0, 16'h0, 1, 1, 16'h20, 16'h2, 0, 16'h0, 0, 0, 0));
`endif
        tbl.push_back(mk(0, 16'h0, 16'h0, 0, 16'h0, 0, 0, 16'h0, 16'h0, 0, 16'h0, 0, 1, 0));
        // fill to full under load misses
        for (int i = 0; i < 8; i++)
            tbl.push_back(mk(1, 16'h40 + 16'(i), 16'h100 + 16'(i), 1, 16'h30,
                             1, 0, 16'h30, 16'h0, 1, 16'h5030, 0, (i == 0), 0));
        // full + miss drops; full + no load accepts while draining
        tbl.push_back(mk(1, 16'h48, 16'h108, 1, 16'h30, 1, 0, 16'h30, 16'h0, 1, 16'h5030, 1, 0, 0));
        tbl.push_back(mk(1, 16'h49, 16'h109, 0, 16'h0, 1, 1, 16'h40, 16'h100, 0, 16'h0, 1, 0, 1));
        tbl.push_back(mk(0, 16'h0, 16'h0, 0, 16'h0, 1, 1, 16'h41, 16'h101, 0, 16'h0, 1, 0, 1));
        tbl.push_back(mk(0, 16'h0, 16'h0, 0, 16'h0, 1, 1, 16'h42, 16'h102, 0, 16'h0, 0, 0, 1));

        foreach (tbl[i]) begin
            drive(tbl[i].w_v, tbl[i].w_addr, tbl[i].w_data, tbl[i].r_v, tbl[i].r_addr);
            #4;
            chk($sformatf("vec%0d mem_v", i), mem_v_o, tbl[i].e_mem_v);
            chk($sformatf("vec%0d full", i), full_o, tbl[i].e_full);
            chk($sformatf("vec%0d empty", i), empty_o, tbl[i].e_empty);
            chk($sformatf("vec%0d overflow", i), overflow_o, tbl[i].e_ovf);
            if (tbl[i].e_mem_v) begin
                chk($sformatf("vec%0d mem_w", i), mem_w_o, tbl[i].e_mem_w);
                chk($sformatf("vec%0d mem_addr", i), mem_addr_o, tbl[i].e_mem_addr);
            end
            if (tbl[i].e_mem_w) chk($sformatf("vec%0d mem_data", i), mem_data_o, tbl[i].e_mem_data);
            if (tbl[i].chk_rd) chk($sformatf("vec%0d r_data", i), r_data_o, tbl[i].e_rdata);
            @(posedge clk);
            #1;
        end

        // async reset in the middle of a drain with five entries buffered
        do_reset(1'b1);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 16'h70 + 16'(i), 16'h700 + 16'(i), 1'b1, 16'h30);
            @(posedge clk);
            #1;
        end
        drive(1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
        #4;
        chk("rst pre mem_v", mem_v_o, 1);
        chk("rst pre mem_w", mem_w_o, 1);
        chk("rst pre addr", mem_addr_o, 16'h70);
        rst = 1'b1;
        #1;
        chk("rst mem_v", mem_v_o, 0);
        chk("rst empty", empty_o, 1);
        chk("rst full", full_o, 0);
        chk("rst overflow", overflow_o, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #4;
            chk("rst idle mem_v", mem_v_o, 0);
            @(posedge clk);
            #1;
        end
        for (int i = 0; i < 5; i++)
            chk($sformatf("rst sram 0x%0h", 16'h70 + i), sram[8'h70 + 8'(i)], 16'h5070 + 16'(i));

        // randomized traffic with pointer wrap; load-heavy first to reach full
        do_reset(1'b1);
        for (int c = 0; c < 400; c++) begin
            model_step($urandom_range(0, 99) < 60, 16'h60 + 16'($urandom_range(0, 11)),
                       16'($urandom), $urandom_range(0, 99) < ((c < 150) ? 85 : 30),
                       16'h60 + 16'($urandom_range(0, 15)));
        end
        for (int c = 0; c < 20 && m_q.size() != 0; c++)
            model_step(1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
        #4;
        chk("final empty", empty_o, 1);
        for (int a = 16'h60; a < 16'h70; a++)
            chk($sformatf("final sram 0x%0h", a), sram[a[7:0]], gold[a[7:0]]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
